// File: rtl/alu_div_sequencer.sv
// -----------------------------------------------------------------------------
// alu_div_sequencer
//   Drives an external combinational ALU through a 32-step restoring unsigned
//   division, one iteration per clock. Each step subtracts the divisor from the
//   shifted partial remainder. Quotient bits come back through the ALU DI->DO
//   shift chain.
//
// Ports
//   clk, rst_n          clock (rising edge) and synchronous active-low reset
//   start               request a division (sampled only in IDLE)
//   dividend, divisor   operands, captured when start is accepted
//   busy                high while iterating (RUN)
//   done                one-cycle pulse when the results are valid
//   quotient, remainder results, held until the next accepted start
//   div_by_zero         raised with done when the divisor was 0
//   alu_a/b/di/inst/ci/firstcyc   ALU operand and control outputs
//   alu_z, alu_do, alu_flags      ALU result, shift-chain output and flags
// -----------------------------------------------------------------------------
module alu_div_sequencer #(
    parameter logic [3:0] SUB_INST = 4'h1,
    parameter logic       SUB_CI   = 1'b1,
    parameter int         STEPS    = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic        busy,
    output logic        done,
    output logic [31:0] quotient,
    output logic [31:0] remainder,
    output logic        div_by_zero,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [31:0] alu_di,
    output logic [3:0]  alu_inst,
    output logic        alu_ci,
    output logic        alu_firstcyc,
    input  logic [31:0] alu_z,
    input  logic [31:0] alu_do,
    input  logic [3:0]  alu_flags
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [5:0] LAST_STEP = 6'(STEPS - 1);

    state_t      state_q, state_d;
    logic [31:0] rem_q, rem_d;
    logic [31:0] q_q, q_d;
    logic [31:0] dvs_q, dvs_d;
    logic [5:0]  cnt_q, cnt_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        dbz_q, dbz_d;
    logic [31:0] quot_q, quot_d;
    logic [31:0] remo_q, remo_d;

    logic [31:0] rs_s;
    logic        take_s;
    logic [31:0] rem_nx_s;
    logic [31:0] q_nx_s;
    logic        unused_alu_s;

    // Zero/ovf flags and the DO carry bit are not needed; q takes its own LSB.
    assign unused_alu_s = ^{alu_flags[3:2], alu_flags[0], alu_do[0]};

    // One restoring step: shift remainder, trial subtract through the ALU.
    // A set rem MSB means the 33-bit shifted value exceeds any divisor, so the
    // subtract is taken regardless of the ALU carry and alu_z is exact mod 2^32.
    assign rs_s     = {rem_q[30:0], q_q[31]};
    assign take_s   = rem_q[31] | alu_flags[1];
    assign rem_nx_s = take_s ? alu_z : rs_s;
    assign q_nx_s   = {alu_do[31:1], take_s};

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rem_q   <= 32'd0;
            q_q     <= 32'd0;
            dvs_q   <= 32'd0;
            cnt_q   <= 6'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
            quot_q  <= 32'd0;
            remo_q  <= 32'd0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            q_q     <= q_d;
            dvs_q   <= dvs_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            dbz_q   <= dbz_d;
            quot_q  <= quot_d;
            remo_q  <= remo_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start && (divisor != 32'd0)) begin
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (cnt_q == LAST_STEP) begin
                    state_d = DONE;
                end else begin
                    state_d = RUN;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath and registered-output next values.
    always_comb begin
        rem_d  = rem_q;
        q_d    = q_q;
        dvs_d  = dvs_q;
        cnt_d  = cnt_q;
        dbz_d  = dbz_q;
        quot_d = quot_q;
        remo_d = remo_q;
        done_d = 1'b0;
        busy_d = (state_d == RUN);
        case (state_q)
            IDLE: begin
                if (start && (divisor != 32'd0)) begin
                    rem_d = 32'd0;
                    q_d   = dividend;
                    dvs_d = divisor;
                    cnt_d = 6'd0;
                    dbz_d = 1'b0;
                end else if (start) begin
                    // Divide by zero completes immediately without iterating.
                    quot_d = 32'hFFFF_FFFF;
                    remo_d = dividend;
                    dbz_d  = 1'b1;
                    done_d = 1'b1;
                end else begin
                    done_d = 1'b0;
                end
            end
            RUN: begin
                rem_d = rem_nx_s;
                q_d   = q_nx_s;
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == LAST_STEP) begin
                    quot_d = q_nx_s;
                    remo_d = rem_nx_s;
                end else begin
                    quot_d = quot_q;
                end
            end
            DONE:    done_d = 1'b1;
            default: done_d = 1'b0;
        endcase
    end

    // ALU drive: live operands only while iterating, idle values otherwise.
    always_comb begin
        alu_a        = 32'd0;
        alu_b        = 32'd0;
        alu_di       = 32'd0;
        alu_inst     = SUB_INST;
        alu_ci       = SUB_CI;
        alu_firstcyc = 1'b0;
        if (state_q == RUN) begin
            alu_a        = rs_s;
            alu_b        = dvs_q;
            alu_di       = q_q;
            alu_firstcyc = (cnt_q == 6'd0);
        end else begin
            alu_firstcyc = 1'b0;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign div_by_zero = dbz_q;
    assign quotient    = quot_q;
    assign remainder   = remo_q;

endmodule

// File: doc/alu_div_sequencer.md
Name: alu_div_sequencer

Overview:
- Multi-cycle controller that drives the combinational datapath ALU through a 32-step restoring unsigned division.
- Sits on the master side of the ALU port bundle. It sources A, B, DI, INST, CI and FirstCyc, and consumes Z, DO and FLAGS.
- Quotient bits are collected through the ALU's DI→DO shift chain, where DO = {DI[30:0], carry}.
- Presents a start/busy/done handshake to the issuing control logic.

Parameters:
- SUB_INST, 4'h1, ALU opcode for Z = A - B with FLAGS[1] = carry (1 = no borrow).
- SUB_CI, 1'b1, value driven on ALU CI during the subtract.
- STEPS, 32, division iterations; fixed to the 32-bit datapath width.

Ports:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  synchronous reset, active-low.
- start  in  1  request a division; sampled only in IDLE.
- dividend  in  32  unsigned dividend, captured when start is accepted.
- divisor  in  32  unsigned divisor, captured when start is accepted.
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse when results are valid.
- quotient  out  32  result; held until next accepted start.
- remainder  out  32  result; held until next accepted start.
- div_by_zero  out  1  set with done when divisor was 0.
- alu_a  out  32  ALU A operand.
- alu_b  out  32  ALU B operand.
- alu_di  out  32  ALU DI shift-chain input.
- alu_inst  out  4  ALU INST.
- alu_ci  out  1  ALU CI.
- alu_firstcyc  out  1  ALU FirstCyc.
- alu_z  in  32  ALU Z result.
- alu_do  in  32  ALU DO shift-chain output.
- alu_flags  in  4  ALU FLAGS {0, zero, carry, ovf}.

Behaviour:
- Reset (rst_n low at a clk edge):
  - state = IDLE.
  - busy, done, div_by_zero, quotient, remainder, step counter and internal rem/q/dvs registers all 0.
  - Reset mid-RUN aborts the operation; no done pulse is produced.
- Internal registers:
  - rem[31:0], q[31:0] (dividend, then quotient), dvs[31:0], cnt[5:0].
- States:
  - IDLE:
    - On start=1 and divisor≠0: rem=0, q=dividend, dvs=divisor, cnt=0, div_by_zero=0 → RUN.
    - On start=1 and divisor=0: quotient=32'hFFFFFFFF, remainder=dividend, div_by_zero=1, done=1 next cycle; stay IDLE.
  - RUN, one iteration per cycle (combinational into the ALU, registered result):
    - rs = {rem[30:0], q[31]}; msb = rem[31].
    - Drive alu_a=rs, alu_b=dvs, alu_di=q, alu_inst=SUB_INST, alu_ci=SUB_CI.
    - alu_firstcyc=1 only when cnt=0, else 0.
    - take = msb | alu_flags[1]. msb=1 means the true 33-bit rs ≥ dvs and the subtract always succeeds; alu_z is exact mod 2^32.
    - rem ← take ? alu_z : rs.
    - q ← {alu_do[31:1], take}, where alu_do[31:1] = q[30:0].
    - cnt ← cnt+1. When cnt=STEPS-1, load quotient/remainder from the next-state q/rem and go to DONE.
  - DONE:
    - done=1 for exactly one cycle, busy=0 → IDLE.
- Outside RUN:
  - alu_a, alu_b, alu_di = 0; alu_inst = SUB_INST; alu_ci = SUB_CI; alu_firstcyc = 0.
- Handshake timing:
  - busy is high from the cycle after start is accepted through the last RUN cycle.
  - start while busy or in DONE is ignored; it is not queued.
- Latency:
  - start sampled at edge 0 → done high in the cycle after edge 33 (32 RUN + 1 DONE).
  - A back-to-back start is accepted at earliest in the IDLE cycle after DONE.
- Results:
  - quotient/remainder change only at completion.
  - They satisfy dividend = quotient·divisor + remainder with remainder < divisor.
  - ALU zero/ovf flags are ignored.

Test Plan:
- 100 / 7 → after 33 cycles: done pulse, quotient=14, remainder=2, div_by_zero=0; busy high for exactly 32 cycles.
- 0xFFFFFFFF / 0x80000001 (exercises the msb=1 path) → quotient=1, remainder=0x7FFFFFFE.
- 0xFFFFFFFF / 1 → quotient=0xFFFFFFFF, remainder=0.
- 5 / 9 → quotient=0, remainder=5.
- 0x12345678 / 0 → done in the next cycle, quotient=0xFFFFFFFF, remainder=0x12345678, div_by_zero=1, busy never asserted.
- Start 1000/3; pulse start with 10/2 at RUN cycle 5 → ignored; results 333 r1.
- Start 1000/3; rst_n low at RUN cycle 10 → all outputs 0 next edge, no done.
- Immediately after reset, 50/5 → 10 r0.
- Every RUN cycle: alu_firstcyc high only on the first, alu_inst=SUB_INST, alu_ci=SUB_CI.
